// File: rtl/memory_access_stage_pkg.sv
// Shared encodings, widths and byte-lane helpers for the memory access stage.
// Used by memory_access_stage and load_aligner.
package memory_access_stage_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int REGADDR_WIDTH = 5;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    MAS_IDLE = 2'd0,
    MAS_REQ  = 2'd1,
    MAS_RESP = 2'd2
  } mas_state_t;

  function automatic logic align_fault(
    input logic [1:0] len,
    input logic [1:0] off
  );
    logic f;
    f = 1'b1;
    unique case (1'b1)
      len == MEM_BYTE: f = 1'b0;
      len == MEM_HALF: f = off[0];
      len == MEM_WORD: f = |off;
      default:         f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [1:0] len,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'hF;
    unique case (1'b1)
      len == MEM_BYTE: m = 4'b0001 << off;
      len == MEM_HALF: m = 4'b0011 << off;
      default:         m = 4'hF;
    endcase
    return m;
  endfunction

  // Replicating the datum across the word puts it in every lane it may land in
  function automatic logic [DATA_WIDTH-1:0] lane_data(
    input logic [1:0]            len,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [DATA_WIDTH-1:0] w;
    w = d;
    unique case (1'b1)
      len == MEM_BYTE: w = {4{d[7:0]}};
      len == MEM_HALF: w = {2{d[15:0]}};
      default:         w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/memory_access_stage_load_aligner.sv
// Load data aligner: picks the addressed byte/half/word out of a read word
// and sign- or zero-extends it.
module load_aligner
  import memory_access_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_offset,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_sb;
  logic                  w_sh;

  assign w_shift = i_rdata >> {i_offset, 3'b000};
  assign w_sb    = ~i_unsigned & w_shift[7];
  assign w_sh    = ~i_unsigned & w_shift[15];

  always_comb begin
    o_data = w_shift;
    unique case (1'b1)
      i_size == MEM_BYTE:
        o_data = {{(DATA_WIDTH-8){w_sb}}, w_shift[7:0]};
      i_size == MEM_HALF:
        o_data = {{(DATA_WIDTH-16){w_sh}}, w_shift[15:0]};
      default:
        o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage: req/ack data-memory transaction, lane alignment, writeback.
// Optional acknowledge timeout enabled by defining MEM_TIMEOUT_EN.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_in,
  input  logic                     loadUnsigned_in,
  input  logic                     store_in,
  input  logic [1:0]               memLength_in,
  input  logic [DATA_WIDTH-1:0]    storeData_in,
  input  logic [DATA_WIDTH-1:0]    address_in,
  input  logic [REGADDR_WIDTH-1:0] writeSelect_in,
  input  logic                     writeEnable_in,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_byteEn,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    result_out,
  output logic [REGADDR_WIDTH-1:0] writeSelect_out,
  output logic                     writeEnable_out,
  output logic                     misaligned_out,
  output logic                     busError_out
);

  mas_state_t r_state;
  mas_state_t w_next;

  logic                     w_mem_op;
  logic                     w_fault;
  logic                     w_accept;
  logic                     w_timeout;
  logic                     w_stall;
  logic                     w_req;
  logic [DATA_WIDTH-1:0]    w_load;

  logic [1:0]               r_off;
  logic [1:0]               r_size;
  logic                     r_uns;
  logic                     r_is_load;
  logic [REGADDR_WIDTH-1:0] r_ws;
  logic                     r_we;
  logic                     r_mem_we;
  logic [DATA_WIDTH-1:0]    r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic [3:0]               r_mem_be;

  assign w_mem_op = load_in | store_in;
  assign w_fault  = w_mem_op &
                    ((load_in & store_in) |
                     align_fault(memLength_in, address_in[1:0]));
  assign w_accept = (r_state == MAS_IDLE) & w_mem_op & ~w_fault;

  load_aligner u_load_aligner (
    .i_rdata    (mem_rdata),
    .i_offset   (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_load)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= MAS_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MAS_IDLE: if (w_accept) w_next = MAS_REQ;
      MAS_REQ: begin
        if (mem_ack)        w_next = MAS_RESP;
        else if (w_timeout) w_next = MAS_IDLE;
      end
      MAS_RESP: w_next = MAS_IDLE;
      default:  w_next = MAS_IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    w_req   = 1'b0;
    unique case (r_state)
      MAS_IDLE: w_stall = w_mem_op & ~w_fault;
      MAS_REQ: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall      = w_stall & ~reset;
  assign mem_req    = w_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_byteEn = r_mem_be;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_out      <= '0;
      writeSelect_out <= '0;
      writeEnable_out <= 1'b0;
      misaligned_out  <= 1'b0;
      r_off           <= '0;
      r_size          <= '0;
      r_uns           <= 1'b0;
      r_is_load       <= 1'b0;
      r_ws            <= '0;
      r_we            <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_be        <= '0;
    end else begin
      writeEnable_out <= 1'b0;
      misaligned_out  <= 1'b0;
      unique case (r_state)
        MAS_IDLE: begin
          if (!w_mem_op) begin
            result_out      <= address_in;
            writeSelect_out <= writeSelect_in;
            writeEnable_out <= writeEnable_in;
          end else if (w_fault) begin
            misaligned_out  <= 1'b1;
          end else begin
            r_off       <= address_in[1:0];
            r_size      <= memLength_in;
            r_uns       <= loadUnsigned_in;
            r_is_load   <= load_in;
            r_ws        <= writeSelect_in;
            r_we        <= writeEnable_in;
            r_mem_we    <= store_in;
            r_mem_addr  <= {address_in[DATA_WIDTH-1:2], 2'b00};
            r_mem_be    <= lane_mask(memLength_in, address_in[1:0]);
            r_mem_wdata <= lane_data(memLength_in, storeData_in);
          end
        end
        MAS_REQ: begin
          if (mem_ack && r_is_load) begin
            result_out      <= w_load;
            writeSelect_out <= r_ws;
            writeEnable_out <= r_we;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo;
  logic          r_bus;

  assign w_timeout = (r_state == MAS_REQ) & ~mem_ack &
                     (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
      r_bus <= 1'b0;
    end else begin
      r_bus <= w_timeout;
      if ((r_state == MAS_REQ) && !mem_ack) r_tmo <= r_tmo + 1'b1;
      else                                  r_tmo <= '0;
    end
  end

  assign busError_out = r_bus;
`else
  assign w_timeout    = 1'b0;
  assign busError_out = 1'b0;
`endif

endmodule
